i2c_slave_mem: RTL and testbench

Synthesizable, parametrised I2C slave with an internal byte memory, auto-incrementing pointer and optional EEPROM write-cycle emulation. Sits on the same open-drain SCL/SDA bus as `i2c_master` and replaces the behavioural slave model as the bus partner in benches and FPGA loopback builds. A side-band debug port lets the bench read memory contents without using I2C traffic.

---
 rtl/i2c_slave_mem.sv | 271 +++++++++++++++++++++++++++
 tb/tb_i2c_slave_mem.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_mem.sv
// i2c_slave_mem: I2C slave with an internal byte memory, auto-incrementing
// pointer and a side-band debug read port. Optional EEPROM write-cycle
// emulation (address phases NACKed after a write) is enabled by the macro
// I2C_SLAVE_MEM_BUSY_NACK_EN.
module i2c_slave_mem #(
  parameter logic [6:0] G_SLAVE_ADDR    = 7'h50,
  parameter int         G_MEM_DEPTH     = 256,
  parameter int         G_PTR_BYTES     = 1,
  parameter int         G_FILTER_LEN    = 3,
  parameter int         G_BUSY_NACK_CNT = 3
) (
  input  logic                           clk_sys,
  input  logic                           rst_n_sys,
  input  logic                           scl_in,
  input  logic                           sda_in,
  output logic                           sda_out_en,
  output logic                           busy,
  output logic                           wr_done,
  output logic [7:0]                     nack_cnt,
  input  logic [$clog2(G_MEM_DEPTH)-1:0] dbg_addr,
  output logic [7:0]                     dbg_rdata
);

  localparam int AW = $clog2(G_MEM_DEPTH);
  localparam int FW = $clog2(G_FILTER_LEN + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_MACK, WAIT_STOP
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [1:0]      scl_sync_r, sda_sync_r;
  logic [FW-1:0]   scl_cnt_r, sda_cnt_r;
  logic            scl_f_r, sda_f_r, scl_d_r, sda_d_r;
  logic            scl_rise_s, scl_fall_s, start_s, stop_s, last_bit_s;
  logic [3:0]      bit_cnt_r;
  logic [7:0]      shift_r, byte_s, ptr_acc_r, nack_cnt_r, dbg_rdata_r;
  logic [1:0]      ptr_bytes_r;
  logic [AW-1:0]   ptr_r, ptr_inc_s;
  logic            ptr_done_r, rw_r, wrote_r, busy_r, oe_r, wr_done_r;
  logic            addr_match_s, bn_active_s, mem_we_s;
  logic [7:0]      mem [G_MEM_DEPTH];

`ifdef I2C_SLAVE_MEM_BUSY_NACK_EN
  logic [7:0]      bn_cnt_r;
  assign bn_active_s = (bn_cnt_r != 8'd0);
`else
  // No write-cycle emulation: a matching address is never refused.
  assign bn_active_s = 1'b0 & (G_BUSY_NACK_CNT != 0);
`endif

  assign scl_rise_s   = scl_f_r & ~scl_d_r;
  assign scl_fall_s   = ~scl_f_r & scl_d_r;
  assign start_s      = scl_f_r & scl_d_r & sda_d_r & ~sda_f_r;
  assign stop_s       = scl_f_r & scl_d_r & ~sda_d_r & sda_f_r;
  assign byte_s       = {shift_r[6:0], sda_f_r};
  assign last_bit_s   = scl_rise_s & (bit_cnt_r == 4'd7);
  assign addr_match_s = (byte_s[7:1] == G_SLAVE_ADDR);
  assign ptr_inc_s    = ptr_r + AW'(1);
  assign mem_we_s     = (state_r == WR_DATA) & last_bit_s & ~stop_s & ~start_s & rst_n_sys;

  assign sda_out_en = oe_r;
  assign busy       = busy_r;
  assign wr_done    = wr_done_r;
  assign nack_cnt   = nack_cnt_r;
  assign dbg_rdata  = dbg_rdata_r;

  // Synchronize SCL/SDA and pass them through a stability filter.
  always_ff @(posedge clk_sys) begin
    if (!rst_n_sys) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_cnt_r  <= {FW{1'b0}};
      sda_cnt_r  <= {FW{1'b0}};
      scl_f_r    <= 1'b1;
      sda_f_r    <= 1'b1;
      scl_d_r    <= 1'b1;
      sda_d_r    <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_in};
      sda_sync_r <= {sda_sync_r[0], sda_in};
      scl_d_r    <= scl_f_r;
      sda_d_r    <= sda_f_r;
      if (scl_sync_r[1] == scl_f_r) begin
        scl_cnt_r <= {FW{1'b0}};
      end else if (scl_cnt_r == FW'(G_FILTER_LEN - 1)) begin
        scl_f_r   <= scl_sync_r[1];
        scl_cnt_r <= {FW{1'b0}};
      end else begin
        scl_cnt_r <= scl_cnt_r + FW'(1);
      end
      if (sda_sync_r[1] == sda_f_r) begin
        sda_cnt_r <= {FW{1'b0}};
      end else if (sda_cnt_r == FW'(G_FILTER_LEN - 1)) begin
        sda_f_r   <= sda_sync_r[1];
        sda_cnt_r <= {FW{1'b0}};
      end else begin
        sda_cnt_r <= sda_cnt_r + FW'(1);
      end
    end
  end

  // Protocol state register.
  always_ff @(posedge clk_sys) begin
    if (!rst_n_sys) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; STOP has priority over START.
  always_comb begin
    state_nxt_s = state_r;
    if (stop_s) begin
      state_nxt_s = IDLE;
    end else if (start_s) begin
      state_nxt_s = ADDR;
    end else begin
      case (state_r)
        ADDR:     if (last_bit_s) state_nxt_s = (addr_match_s && !bn_active_s) ? ADDR_ACK : WAIT_STOP;
                  else state_nxt_s = ADDR;
        ADDR_ACK: if (scl_rise_s) state_nxt_s = rw_r ? RD_DATA : (ptr_done_r ? WR_DATA : PTR);
                  else state_nxt_s = ADDR_ACK;
        PTR:      if (last_bit_s) state_nxt_s = PTR_ACK;
                  else state_nxt_s = PTR;
        PTR_ACK:  if (scl_rise_s) state_nxt_s = (ptr_bytes_r == 2'(G_PTR_BYTES)) ? WR_DATA : PTR;
                  else state_nxt_s = PTR_ACK;
        WR_DATA:  if (last_bit_s) state_nxt_s = WR_ACK;
                  else state_nxt_s = WR_DATA;
        WR_ACK:   if (scl_rise_s) state_nxt_s = WR_DATA;
                  else state_nxt_s = WR_ACK;
        RD_DATA:  if (last_bit_s) state_nxt_s = RD_MACK;
                  else state_nxt_s = RD_DATA;
        RD_MACK:  if (scl_rise_s) state_nxt_s = sda_f_r ? WAIT_STOP : RD_DATA;
                  else state_nxt_s = RD_MACK;
        IDLE:      state_nxt_s = IDLE;
        WAIT_STOP: state_nxt_s = WAIT_STOP;
        default:   state_nxt_s = IDLE;
      endcase
    end
  end

  // Shift register, pointer, SDA drive and status flags; SDA only moves on SCL fall.
  always_ff @(posedge clk_sys) begin
    if (!rst_n_sys) begin
      oe_r        <= 1'b0;
      busy_r      <= 1'b0;
      wr_done_r   <= 1'b0;
      nack_cnt_r  <= 8'd0;
      ptr_r       <= {AW{1'b0}};
      ptr_acc_r   <= 8'd0;
      ptr_bytes_r <= 2'd0;
      ptr_done_r  <= 1'b0;
      rw_r        <= 1'b0;
      wrote_r     <= 1'b0;
      bit_cnt_r   <= 4'd0;
      shift_r     <= 8'd0;
`ifdef I2C_SLAVE_MEM_BUSY_NACK_EN
      bn_cnt_r    <= 8'd0;
`endif
    end else begin
      wr_done_r <= stop_s & wrote_r;
      if (stop_s) begin
        oe_r       <= 1'b0;
        busy_r     <= 1'b0;
        wrote_r    <= 1'b0;
        ptr_done_r <= 1'b0;
`ifdef I2C_SLAVE_MEM_BUSY_NACK_EN
        if (wrote_r) bn_cnt_r <= 8'(G_BUSY_NACK_CNT);
`endif
      end else if (start_s) begin
        oe_r      <= 1'b0;
        bit_cnt_r <= 4'd0;
      end else begin
        case (state_r)
          ADDR: begin
            if (scl_rise_s) begin
              shift_r   <= byte_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
            if (last_bit_s) begin
              rw_r   <= byte_s[0];
              busy_r <= addr_match_s & ~bn_active_s;
              if (addr_match_s && bn_active_s) begin
                if (nack_cnt_r != 8'hFF) nack_cnt_r <= nack_cnt_r + 8'd1;
`ifdef I2C_SLAVE_MEM_BUSY_NACK_EN
                bn_cnt_r <= bn_cnt_r - 8'd1;
`endif
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall_s) oe_r <= 1'b1;
            if (scl_rise_s) begin
              bit_cnt_r   <= 4'd0;
              ptr_acc_r   <= 8'd0;
              ptr_bytes_r <= 2'd0;
              if (rw_r) shift_r <= mem[ptr_r];
            end
          end
          PTR: begin
            if (scl_fall_s) oe_r <= 1'b0;
            if (scl_rise_s) begin
              shift_r   <= byte_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
            if (last_bit_s) begin
              ptr_acc_r   <= byte_s;
              ptr_bytes_r <= ptr_bytes_r + 2'd1;
              if (ptr_bytes_r + 2'd1 == 2'(G_PTR_BYTES)) begin
                ptr_r      <= AW'({ptr_acc_r, byte_s});
                ptr_done_r <= 1'b1;
              end
            end
          end
          WR_DATA: begin
            if (scl_fall_s) oe_r <= 1'b0;
            if (scl_rise_s) begin
              shift_r   <= byte_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
            if (last_bit_s) begin
              ptr_r   <= ptr_inc_s;
              wrote_r <= 1'b1;
            end
          end
          PTR_ACK, WR_ACK: begin
            if (scl_fall_s) oe_r <= 1'b1;
            if (scl_rise_s) bit_cnt_r <= 4'd0;
          end
          RD_DATA: begin
            if (scl_fall_s) oe_r <= ~shift_r[7];
            if (scl_rise_s) begin
              shift_r   <= {shift_r[6:0], 1'b0};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
          RD_MACK: begin
            if (scl_fall_s) oe_r <= 1'b0;
            if (scl_rise_s) begin
              bit_cnt_r <= 4'd0;
              if (!sda_f_r) begin
                ptr_r   <= ptr_inc_s;
                shift_r <= mem[ptr_inc_s];
              end else begin
                busy_r <= 1'b0;
              end
            end
          end
          default: oe_r <= 1'b0;
        endcase
      end
    end
  end

  // Byte memory; contents are deliberately untouched by reset.
  always_ff @(posedge clk_sys) begin
    if (mem_we_s) mem[ptr_r] <= byte_s;
  end

  // Registered debug read; a same-cycle I2C write returns the old byte.
  always_ff @(posedge clk_sys) begin
    if (!rst_n_sys) begin
      dbg_rdata_r <= 8'd0;
    end else begin
      dbg_rdata_r <= mem[dbg_addr];
    end
  end

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Directed bench for i2c_slave_mem: the bench acts as the I2C master on an
// open-drain bus and checks ACKs, read data, debug-port contents and status.
module tb_i2c_slave_mem;

`ifdef I2C_SLAVE_MEM_BUSY_NACK_EN
  localparam int BN = 3;
`else
  localparam int BN = 0;
`endif
  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] dbg_addr = 8'd0;
  logic       sda_line;
  logic       sda_out_en, busy, wr_done;
  logic [7:0] nack_cnt, dbg_rdata;

  int checks = 0;
  int failures = 0;
  int wr_pulses = 0;
  int drive_cnt = 0;
  int busy_cnt = 0;

  assign sda_line = sda_m & ~sda_out_en;

  i2c_slave_mem #(.G_BUSY_NACK_CNT(3)) dut (
    .clk_sys(clk), .rst_n_sys(rst_n), .scl_in(scl_m), .sda_in(sda_line),
    .sda_out_en(sda_out_en), .busy(busy), .wr_done(wr_done), .nack_cnt(nack_cnt),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_done) wr_pulses <= wr_pulses + 1;
    if (sda_out_en) drive_cnt <= drive_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_c();
    sda_m = 1'b1; scl_m = 1'b1; #(T);
    sda_m = 1'b0; #(T);
    scl_m = 1'b0; #(T);
  endtask

  task automatic rstart_c();
    sda_m = 1'b1; #(T);
    scl_m = 1'b1; #(T);
    sda_m = 1'b0; #(T);
    scl_m = 1'b0; #(T);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; #(T);
    scl_m = 1'b1; #(T);
    sda_m = 1'b1; #(T);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #(T);
      scl_m = 1'b1; #(T);
      scl_m = 1'b0; #(T);
    end
    sda_m = 1'b1; #(T);
    scl_m = 1'b1; #(T/2);
    ack = sda_line; #(T/2);
    scl_m = 1'b0; #(T);
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; #(T);
      scl_m = 1'b1; #(T/2);
      d[i] = sda_line; #(T/2);
      scl_m = 1'b0; #(T);
    end
    sda_m = nack; #(T);
    scl_m = 1'b1; #(T);
    scl_m = 1'b0; #(T);
  endtask

  task automatic dbg_rd(input logic [7:0] a, output logic [7:0] d);
    dbg_addr = a; #30;
    d = dbg_rdata;
  endtask

  task automatic polls();
    logic a;
    for (int i = 0; i <= BN; i++) begin
      start_c();
      wbyte(8'hA0, a);
      chk("poll_ack", 32'(a), (i < BN) ? 32'h1 : 32'h0);
      stop_c();
      #200;
    end
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         d0, b0;

    // reset state
    #100;
    chk("rst_sda_out_en", 32'(sda_out_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wr_done", 32'(wr_done), 32'h0);
    chk("rst_nack_cnt", 32'(nack_cnt), 32'h0);
    chk("rst_dbg_rdata", 32'(dbg_rdata), 32'h0);
    rst_n = 1'b1;
    #200;

    // write ptr=0x10, data A5 5A
    start_c();
    wbyte(8'hA0, a); chk("w1_addr_ack", 32'(a), 32'h0);
    chk("w1_busy", 32'(busy), 32'h1);
    wbyte(8'h10, a); chk("w1_ptr_ack", 32'(a), 32'h0);
    wbyte(8'hA5, a); chk("w1_d0_ack", 32'(a), 32'h0);
    wbyte(8'h5A, a); chk("w1_d1_ack", 32'(a), 32'h0);
    stop_c();
    #200;
    chk("w1_wr_done_pulses", 32'(wr_pulses), 32'h1);
    dbg_rd(8'h10, d); chk("w1_mem10", 32'(d), 32'hA5);
    dbg_rd(8'h11, d); chk("w1_mem11", 32'(d), 32'h5A);
    polls();
    chk("w1_nack_cnt", 32'(nack_cnt), 32'(BN));

    // set ptr=0x10, repeated START, read two bytes
    start_c();
    wbyte(8'hA0, a); chk("r1_addr_ack", 32'(a), 32'h0);
    wbyte(8'h10, a); chk("r1_ptr_ack", 32'(a), 32'h0);
    rstart_c();
    wbyte(8'hA1, a); chk("r1_raddr_ack", 32'(a), 32'h0);
    rbyte(1'b0, d); chk("r1_byte0", 32'(d), 32'hA5);
    rbyte(1'b1, d); chk("r1_byte1", 32'(d), 32'h5A);
    chk("r1_busy_after_nack", 32'(busy), 32'h0);
    stop_c();
    #200;
    chk("r1_wr_done_pulses", 32'(wr_pulses), 32'h1);

    // pointer wrap-around at the top of memory
    start_c();
    wbyte(8'hA0, a); chk("wrap_addr_ack", 32'(a), 32'h0);
    wbyte(8'hFF, a); chk("wrap_ptr_ack", 32'(a), 32'h0);
    wbyte(8'h11, a); chk("wrap_d0_ack", 32'(a), 32'h0);
    wbyte(8'h22, a); chk("wrap_d1_ack", 32'(a), 32'h0);
    stop_c();
    #200;
    chk("wrap_wr_done_pulses", 32'(wr_pulses), 32'h2);
    dbg_rd(8'hFF, d); chk("wrap_memFF", 32'(d), 32'h11);
    dbg_rd(8'h00, d); chk("wrap_mem00", 32'(d), 32'h22);
    polls();
    chk("wrap_nack_cnt", 32'(nack_cnt), 32'(2 * BN));

    // address mismatch (0x51): no drive, no busy, nothing written
    d0 = drive_cnt;
    b0 = busy_cnt;
    start_c();
    wbyte(8'hA2, a); chk("mis_addr_nack", 32'(a), 32'h1);
    wbyte(8'h00, a); chk("mis_byte_nack", 32'(a), 32'h1);
    wbyte(8'h77, a); chk("mis_data_nack", 32'(a), 32'h1);
    stop_c();
    #200;
    chk("mis_drive_cycles", 32'(drive_cnt), 32'(d0));
    chk("mis_busy_cycles", 32'(busy_cnt), 32'(b0));
    chk("mis_nack_cnt", 32'(nack_cnt), 32'(2 * BN));
    chk("mis_wr_done_pulses", 32'(wr_pulses), 32'h2);
    dbg_rd(8'h00, d); chk("mis_mem00", 32'(d), 32'h22);
    dbg_rd(8'h10, d); chk("mis_mem10", 32'(d), 32'hA5);

    // pointer-only write to 0x11, then reset while the slave drives bit 7 (0) of 0x5A
    start_c();
    wbyte(8'hA0, a); chk("rr_addr_ack", 32'(a), 32'h0);
    wbyte(8'h11, a); chk("rr_ptr_ack", 32'(a), 32'h0);
    stop_c();
    #200;
    chk("rr_no_wr_done", 32'(wr_pulses), 32'h2);
    start_c();
    wbyte(8'hA1, a); chk("rr_raddr_ack", 32'(a), 32'h0);
    chk("rr_drive_bit7", 32'(sda_out_en), 32'h1);
    rst_n = 1'b0;
    #10;
    chk("rr_sda_released", 32'(sda_out_en), 32'h0);
    #20;
    chk("rr_busy", 32'(busy), 32'h0);
    chk("rr_nack_cnt", 32'(nack_cnt), 32'h0);
    chk("rr_dbg_rdata", 32'(dbg_rdata), 32'h0);
    rst_n = 1'b1;
    #20;
    stop_c();
    #200;

    // read without pointer phase starts at address 0 after reset
    start_c();
    wbyte(8'hA1, a); chk("rr2_addr_ack", 32'(a), 32'h0);
    rbyte(1'b1, d); chk("rr2_byte_ptr0", 32'(d), 32'h22);
    stop_c();
    #200;
    chk("rr2_busy_idle", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
